// File: rtl/schieber_zuteiler.sv
// Round-robin arbiter sharing one rotator between requesters A (ALU) and B (byte align); 1-cycle latency.
// Backpressure: a held result blocks both request channels until its owner consumer takes it. Option: STATISTIK_EN.
module schieber_zuteiler #(
    parameter int unsigned BREITE        = 32,
    parameter int unsigned LOG2BREITE    = 5
`ifdef STATISTIK_EN
    ,
    parameter int unsigned ZAEHLERBREITE = 16
`endif
) (
    input  logic                  Takt,
    input  logic                  Reset,
    input  logic                  A_Gueltig,
    output logic                  A_Bereit,
    input  logic [BREITE-1:0]     A_Zahl,
    input  logic [LOG2BREITE-1:0] A_Stellen,
    input  logic                  A_Rechts,
    input  logic                  B_Gueltig,
    output logic                  B_Bereit,
    input  logic [BREITE-1:0]     B_Zahl,
    input  logic [LOG2BREITE-1:0] B_Stellen,
    input  logic                  B_Rechts,
    output logic                  EA_Gueltig,
    input  logic                  EA_Bereit,
    output logic                  EB_Gueltig,
    input  logic                  EB_Bereit,
    output logic [BREITE-1:0]     Ergebnis
`ifdef STATISTIK_EN
    ,
    output logic [ZAEHLERBREITE-1:0] ZaehlerA,
    output logic [ZAEHLERBREITE-1:0] ZaehlerB
`endif
);

    typedef enum logic {LEER, VOLL} zustand_t;

    localparam logic SEITE_A = 1'b0;
    localparam logic SEITE_B = 1'b1;

    zustand_t          zustand_q, zustand_d;
    logic              besitzer_q, besitzer_d;
    logic              letzter_q, letzter_d;
    logic [BREITE-1:0] ergebnis_q, ergebnis_d;

    logic                  frei;
    logic                  xfer_a, xfer_b;
    logic [BREITE-1:0]     sel_zahl;
    logic [LOG2BREITE-1:0] sel_stellen;
    logic                  sel_rechts;
    logic [BREITE-1:0]     rotiert;

    // Index arithmetic in LOG2BREITE bits wraps modulo BREITE for free.
    function automatic logic [BREITE-1:0] rotieren(input logic [BREITE-1:0]     zahl,
                                                   input logic [LOG2BREITE-1:0] stellen,
                                                   input logic                  rechts);
        logic [BREITE-1:0]     erg;
        logic [LOG2BREITE-1:0] pos;
        logic [LOG2BREITE-1:0] idx;
        erg = '0;
        for (int i = 0; i < BREITE; i++) begin
            pos    = LOG2BREITE'(i);
            idx    = rechts ? (pos + stellen) : (pos - stellen);
            erg[i] = zahl[idx];
        end
        return erg;
    endfunction

    assign frei = (zustand_q == LEER) ||
                  ((besitzer_q == SEITE_A) ? EA_Bereit : EB_Bereit);

    assign A_Bereit = frei && (!B_Gueltig || (letzter_q == SEITE_B));
    assign B_Bereit = frei && (!A_Gueltig || (letzter_q == SEITE_A));

    assign xfer_a = A_Gueltig && A_Bereit;
    assign xfer_b = B_Gueltig && B_Bereit;

    assign sel_zahl    = xfer_b ? B_Zahl    : A_Zahl;
    assign sel_stellen = xfer_b ? B_Stellen : A_Stellen;
    assign sel_rechts  = xfer_b ? B_Rechts  : A_Rechts;
    assign rotiert     = rotieren(sel_zahl, sel_stellen, sel_rechts);

    always_comb begin
        zustand_d  = zustand_q;
        besitzer_d = besitzer_q;
        letzter_d  = letzter_q;
        ergebnis_d = ergebnis_q;
        if (xfer_a || xfer_b) begin
            zustand_d  = VOLL;
            besitzer_d = xfer_b ? SEITE_B : SEITE_A;
            letzter_d  = xfer_b ? SEITE_B : SEITE_A;
            ergebnis_d = rotiert;
        end else if (zustand_q == VOLL && frei) begin
            zustand_d = LEER;
        end
    end

    always_ff @(posedge Takt) begin
        if (Reset) begin
            zustand_q  <= LEER;
            besitzer_q <= SEITE_A;
            letzter_q  <= SEITE_B;
            ergebnis_q <= '0;
        end else begin
            zustand_q  <= zustand_d;
            besitzer_q <= besitzer_d;
            letzter_q  <= letzter_d;
            ergebnis_q <= ergebnis_d;
        end
    end

    assign EA_Gueltig = (zustand_q == VOLL) && (besitzer_q == SEITE_A);
    assign EB_Gueltig = (zustand_q == VOLL) && (besitzer_q == SEITE_B);
    assign Ergebnis   = ergebnis_q;

`ifdef STATISTIK_EN
    logic [ZAEHLERBREITE-1:0] zaehler_a_q, zaehler_a_d;
    logic [ZAEHLERBREITE-1:0] zaehler_b_q, zaehler_b_d;

    // Saturating grant counters: stick at all-ones.
    always_comb begin
        zaehler_a_d = zaehler_a_q;
        zaehler_b_d = zaehler_b_q;
        if (xfer_a && (zaehler_a_q != '1)) zaehler_a_d = zaehler_a_q + 1'b1;
        if (xfer_b && (zaehler_b_q != '1)) zaehler_b_d = zaehler_b_q + 1'b1;
    end

    always_ff @(posedge Takt) begin
        if (Reset) begin
            zaehler_a_q <= '0;
            zaehler_b_q <= '0;
        end else begin
            zaehler_a_q <= zaehler_a_d;
            zaehler_b_q <= zaehler_b_d;
        end
    end

    assign ZaehlerA = zaehler_a_q;
    assign ZaehlerB = zaehler_b_q;
`endif

endmodule
